// File: rtl/turbo_rsc_encoder.sv
// Dual 8-state RSC encoder (g0=1+D2+D3, g1=1+D+D3) with 3-step trellis termination per block.
// All outputs registered one cycle after the accepted input; there is no backpressure, and input arriving during TAIL/DONE is dropped and flagged.
module turbo_rsc_encoder #(
   parameter int BLOCK_LEN = 4096,
   parameter int CNT_W     = 12
) (
   input  logic clk,
   input  logic reset_n,
   input  logic bin_in,
   input  logic bin_int_in,
   input  logic valid_in,
   input  logic mode_in,
   output logic sys_out,
   output logic sys_int_out,
   output logic par1_out,
   output logic par2_out,
   output logic valid_out,
   output logic tail_out,
   output logic block_done,
   output logic err_out
);

   typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

   typedef struct packed {
      logic sys;
      logic sys_int;
      logic par1;
      logic par2;
      logic vld;
      logic tail;
      logic done;
   } out_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       tcnt_q, tcnt_d;
   logic [2:0]       enc1_q, enc1_d, enc2_q, enc2_d;
   logic             mode_q;
   logic             err_q, err_d;
   out_t             out_q, out_d;

   logic [4:0]       st1, st2;
   logic             accept, last_bit, mode_rise, in_tail;

   // State is {d3,d2,d1}; returns {effective input, parity, next state}.
   // In tail mode the input cancels the feedback so the register drains to zero.
   function automatic logic [4:0] rsc_step(input logic [2:0] s, input logic u, input logic tail);
      logic ue;
      logic a;
      ue = tail ? (s[1] ^ s[2]) : u;
      a  = ue ^ s[1] ^ s[2];
      return {ue, a ^ s[0] ^ s[2], s[1], s[0], a};
   endfunction

   always_comb begin
      in_tail   = (state_q == TAIL);
      st1       = rsc_step(enc1_q, bin_in, in_tail);
      st2       = rsc_step(enc2_q, bin_int_in, in_tail);
      accept    = valid_in && (state_q == IDLE || state_q == DATA);
      last_bit  = (cnt_q == LAST_CNT);
      mode_rise = mode_in && !mode_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      enc1_d  = enc1_q;
      enc2_d  = enc2_q;
      out_d   = '0;
      err_d   = err_q | (valid_in && (state_q == TAIL || state_q == DONE));

      if (accept) begin
         enc1_d     = st1[2:0];
         enc2_d     = st2[2:0];
         out_d.sys  = bin_in;
         out_d.par1 = st1[3];
         out_d.par2 = st2[3];
         out_d.vld  = 1'b1;
         // Saturate at the final bit so the counter can never wrap.
         cnt_d      = last_bit ? cnt_q : cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (accept) state_d = last_bit ? TAIL : DATA;
         end
         DATA: begin
            if ((accept && last_bit) || mode_rise) begin
               state_d = TAIL;
               tcnt_d  = '0;
            end
         end
         TAIL: begin
            enc1_d        = st1[2:0];
            enc2_d        = st2[2:0];
            out_d.sys     = st1[4];
            out_d.sys_int = st2[4];
            out_d.par1    = st1[3];
            out_d.par2    = st2[3];
            out_d.vld     = 1'b1;
            out_d.tail    = 1'b1;
            tcnt_d        = tcnt_q + 2'd1;
            if (tcnt_q == 2'd2) state_d = DONE;
         end
         DONE: begin
            out_d.done = 1'b1;
            cnt_d      = '0;
            tcnt_d     = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         enc1_q  <= '0;
         enc2_q  <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         enc1_q  <= enc1_d;
         enc2_q  <= enc2_d;
         mode_q  <= mode_in;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   assign sys_out     = out_q.sys;
   assign sys_int_out = out_q.sys_int;
   assign par1_out    = out_q.par1;
   assign par2_out    = out_q.par2;
   assign valid_out   = out_q.vld;
   assign tail_out    = out_q.tail;
   assign block_done  = out_q.done;
   assign err_out     = err_q;

endmodule
